// File: rtl/skyhop_pkg.sv
// rtl/skyhop_pkg.sv - shared types and constants for the skyhop character datapath
// Holds the jump_ctl state encoding, geometry defaults, datapath widths and the
// key codes the game state machine decodes into jump commands.
package skyhop_pkg;

    localparam int DEF_COLS    = 8;
    localparam int DEF_COL_W   = 64;
    localparam int DEF_Y_STAND = 400;
    localparam int DEF_Y_FLOOR = 700;

    // PS/2 set-2 make codes used by the game state machine
    localparam logic [7:0] K_LEFT     = 8'h6B;
    localparam logic [7:0] K_RIGHT    = 8'h74;
    localparam logic [7:0] K_SPACEBAR = 8'h29;

    localparam int X_W  = 11;
    localparam int Y_W  = 11;
    localparam int VY_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FLY   = 3'd2,
        ST_CHECK = 3'd3,
        ST_FALL  = 3'd4,
        ST_DOWN  = 3'd5
    } jump_state_t;

endpackage

// File: rtl/jump_trajectory.sv
// rtl/jump_trajectory.sv - character position/velocity registers and per-frame step
// Ports:
//   clk, rst (async active-low), init (sync reload of start position)
//   vy_load/vy_val  load vertical speed
//   fly_step/fly_left  flight step: y += vy, vy += 1, x += -/+DX
//   fall_step          fall step: y += vy clamped at floor, vy += 1 saturating
//   snap_en/snap_x     overwrite x with a column centre
//   char_x, char_y     current pixel position
//   floor_hit          the next fall step reaches or passes the floor
module jump_trajectory
    import skyhop_pkg::*;
#(
    parameter int X_INIT  = 224,
    parameter int Y_INIT  = DEF_Y_STAND,
    parameter int Y_FLOOR = DEF_Y_FLOOR,
    parameter int DX      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   vy_load,
    input  logic signed [VY_W-1:0] vy_val,
    input  logic                   fly_step,
    input  logic                   fly_left,
    input  logic                   fall_step,
    input  logic                   snap_en,
    input  logic [X_W-1:0]         snap_x,
    output logic [X_W-1:0]         char_x,
    output logic [9:0]             char_y,
    output logic                   floor_hit
);

    localparam logic signed [VY_W-1:0] VY_MAX    = VY_W'(15);
    localparam logic signed [VY_W-1:0] VY_ONE    = VY_W'(1);
    localparam logic signed [Y_W-1:0]  Y_FLOOR_S = Y_W'(Y_FLOOR);

    logic signed [Y_W-1:0]  y;
    logic signed [Y_W-1:0]  y_sum;
    logic signed [VY_W-1:0] vy;

    // vy is sign-extended so upward (negative) speeds subtract
    assign y_sum     = y + Y_W'(vy);
    assign floor_hit = (y_sum >= Y_FLOOR_S);
    assign char_y    = y[9:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_x <= X_W'(X_INIT);
            y      <= Y_W'(Y_INIT);
            vy     <= '0;
        end else if (init) begin
            char_x <= X_W'(X_INIT);
            y      <= Y_W'(Y_INIT);
            vy     <= '0;
        end else begin
            if (vy_load) begin
                vy <= vy_val;
            end
            if (fly_step) begin
                y      <= y_sum;
                vy     <= vy + VY_ONE;
                char_x <= fly_left ? char_x - X_W'(DX) : char_x + X_W'(DX);
            end
            if (fall_step) begin
                y  <= floor_hit ? Y_FLOOR_S : y_sum;
                vy <= (vy == VY_MAX) ? vy : vy + VY_ONE;
            end
            if (snap_en) begin
                char_x <= snap_x;
            end
        end
    end

endmodule

// File: rtl/jump_ctl.sv
// rtl/jump_ctl.sv - jump/fall sequencer and landing check for the skyhop character
// Build option: define SKYHOP_EDGE_WRAP_EN to make the target column wrap at the edges.
// Ports:
//   clk, rst (async active-low)
//   frame_tick            one pulse per video frame, paces all motion
//   game_init             sync reload of start position, clears jump_fail
//   jump_left/jump_right  one-cycle jump commands (ignored unless idle, or if both high)
//   layer_mask            block present per column of the current layer
//   char_x, char_y        character pixel position
//   col                   current or target column
//   busy                  in flight or falling
//   character_landed      one-cycle pulse at end of flight or fall
//   jump_fail             high from a failed landing until game_init
module jump_ctl
    import skyhop_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int COL_W     = DEF_COL_W,
    parameter int X_OFF     = 32,
    parameter int Y_STAND   = DEF_Y_STAND,
    parameter int Y_FLOOR   = DEF_Y_FLOOR,
    parameter int JUMP_V    = 8,
    parameter int DX        = 4,
    parameter int START_COL = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    game_init,
    input  logic                    jump_left,
    input  logic                    jump_right,
    input  logic [COLS-1:0]         layer_mask,
    output logic [10:0]             char_x,
    output logic [9:0]              char_y,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    busy,
    output logic                    character_landed,
    output logic                    jump_fail
);

    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = $clog2(2*JUMP_V+1);

    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(2*JUMP_V);
    localparam logic [CW-1:0]          COL_START = CW'(START_COL);
    localparam int                     X_START   = X_OFF + START_COL*COL_W;
    localparam logic signed [VY_W-1:0] VY_JUMP   = VY_W'(-JUMP_V);
    localparam logic signed [VY_W-1:0] VY_FALL   = VY_W'(1);
    localparam logic signed [CW+1:0]   T_ONE     = (CW+2)'(1);
    localparam logic signed [CW+1:0]   T_COLS    = (CW+2)'(COLS);

    jump_state_t          state;
    logic                 dir_left;
    logic [CNT_W-1:0]     cnt;
    logic                 cmd;
    logic                 start_jump;
    logic                 start_fall;
    logic                 fly_step;
    logic                 fall_step;
    logic                 floor_hit;
    logic signed [CW+1:0] t_s;
    logic                 t_in;
    logic                 t_ok;
    logic [CW-1:0]        t_col;
    logic [X_W-1:0]       snap_x;

    assign cmd        = jump_left ^ jump_right;
    assign start_fall = (state == ST_IDLE) && jump_fail;
    assign start_jump = (state == ST_IDLE) && !jump_fail && cmd;
    // the tick that releases ARM is also the first motion step
    assign fly_step   = frame_tick && ((state == ST_ARM) || (state == ST_FLY));
    assign fall_step  = frame_tick && (state == ST_FALL);

    // Target column with two guard bits so col-1 at column 0 goes negative
    // instead of aliasing to a valid column.
    always_comb begin
        t_s   = dir_left ? ($signed({2'b00, col}) - T_ONE) : ($signed({2'b00, col}) + T_ONE);
        t_in  = !t_s[CW+1] && (t_s < T_COLS);
        t_col = t_s[CW-1:0];
`ifdef SKYHOP_EDGE_WRAP_EN
        if (!t_in) begin
            t_col = t_s[CW+1] ? CW'(COLS-1) : '0;
        end
        t_ok = layer_mask[t_col];
`else
        // off-edge target is clamped only so the character is drawn on screen
        if (!t_in) begin
            t_col = t_s[CW+1] ? '0 : CW'(COLS-1);
        end
        t_ok = t_in && layer_mask[t_col];
`endif
        snap_x = X_W'(X_OFF) + X_W'(t_col) * X_W'(COL_W);
    end

    jump_trajectory #(
        .X_INIT  (X_START),
        .Y_INIT  (Y_STAND),
        .Y_FLOOR (Y_FLOOR),
        .DX      (DX)
    ) u_traj (
        .clk       (clk),
        .rst       (rst),
        .init      (game_init),
        .vy_load   (start_jump || start_fall),
        .vy_val    (start_fall ? VY_FALL : VY_JUMP),
        .fly_step  (fly_step),
        .fly_left  (dir_left),
        .fall_step (fall_step),
        .snap_en   (state == ST_CHECK),
        .snap_x    (snap_x),
        .char_x    (char_x),
        .char_y    (char_y),
        .floor_hit (floor_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            col              <= COL_START;
            busy             <= 1'b0;
            character_landed <= 1'b0;
            jump_fail        <= 1'b0;
            dir_left         <= 1'b0;
            cnt              <= '0;
        end else if (game_init) begin
            state            <= ST_IDLE;
            col              <= COL_START;
            busy             <= 1'b0;
            character_landed <= 1'b0;
            jump_fail        <= 1'b0;
            dir_left         <= 1'b0;
            cnt              <= '0;
        end else begin
            character_landed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (jump_fail) begin
                        busy  <= 1'b1;
                        state <= ST_FALL;
                    end else if (cmd) begin
                        dir_left <= jump_left;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (frame_tick) begin
                        cnt   <= CNT_W'(1);
                        state <= ST_FLY;
                    end
                end
                ST_FLY: begin
                    if (frame_tick) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    col              <= t_col;
                    character_landed <= 1'b1;
                    busy             <= 1'b0;
                    if (!t_ok) begin
                        jump_fail <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                ST_FALL: begin
                    if (fall_step && floor_hit) begin
                        character_landed <= 1'b1;
                        busy             <= 1'b0;
                        state            <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_ctl.sv
// tb/tb_jump_ctl.sv - directed scoreboard bench for jump_ctl
module tb_jump_ctl;

    localparam int X_OFF     = 32;
    localparam int COL_W     = 64;
    localparam int Y_STAND   = 400;
    localparam int Y_FLOOR   = 700;
    localparam int JUMP_V    = 8;
    localparam int START_COL = 3;

    typedef struct {
        int col;
        int x;
        bit fail;
        bit chk_x;
    } land_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        game_init;
    logic        jump_left;
    logic        jump_right;
    logic [7:0]  layer_mask;
    logic [10:0] char_x;
    logic [9:0]  char_y;
    logic [2:0]  col;
    logic        busy;
    logic        character_landed;
    logic        jump_fail;

    land_t land_q[$];
    int    y_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    int    landed_cnt = 0;
    int    double_cnt = 0;
    logic  prev_landed = 1'b0;
    int    cur_col;

    always #5 clk = ~clk;

    jump_ctl dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .game_init        (game_init),
        .jump_left        (jump_left),
        .jump_right       (jump_right),
        .layer_mask       (layer_mask),
        .char_x           (char_x),
        .char_y           (char_y),
        .col              (col),
        .busy             (busy),
        .character_landed (character_landed),
        .jump_fail        (jump_fail)
    );

    always @(negedge clk) begin
        if (character_landed === 1'b1) begin
            landed_cnt++;
            if (prev_landed === 1'b1) double_cnt++;
        end
        prev_landed = character_landed;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_col"}, col, START_COL);
        check({tag, "_x"}, char_x, X_OFF + START_COL*COL_W);
        check({tag, "_y"}, char_y, Y_STAND);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fail"}, jump_fail, 0);
        check({tag, "_landed"}, character_landed, 0);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_init();
        game_init = 1'b1;
        cyc();
        game_init = 1'b0;
        cur_col = START_COL;
    endtask

    function automatic land_t exp_land(input int c, input bit left, input logic [7:0] m);
        land_t r;
        int    t;
        t = left ? c - 1 : c + 1;
        r.chk_x = 1'b1;
`ifdef SKYHOP_EDGE_WRAP_EN
        if (t < 0) t = 7;
        else if (t > 7) t = 0;
        r.fail = !m[t];
`else
        if (t < 0 || t > 7) begin
            r.chk_x = 1'b0;
            t = (t < 0) ? 0 : 7;
            r.fail = 1'b1;
        end else begin
            r.fail = !m[t];
        end
`endif
        r.col = t;
        r.x = X_OFF + t*COL_W;
        return r;
    endfunction

    task automatic do_jump(input bit left, input bit stray, input bit init_at_check);
        land_t e;
        int    y;
        int    vy;
        int    base;
        int    w;
        land_q.push_back(exp_land(cur_col, left, layer_mask));
        base = landed_cnt;
        check("idle_busy", busy, 0);
        jump_left = left;
        jump_right = !left;
        cyc();
        jump_left = 1'b0;
        jump_right = 1'b0;
        check("cmd_busy", busy, 1);
        y = Y_STAND;
        vy = -JUMP_V;
        for (int k = 1; k <= 2*JUMP_V+1; k++) begin
            y += vy;
            vy++;
            y_q.push_back(y);
            if (stray && k == 5) begin
                jump_right = 1'b1;
                cyc();
                jump_right = 1'b0;
            end
            tick();
            check("fly_y", char_y, y_q.pop_front());
            if (k == JUMP_V) check("peak_y", char_y, 364);
            if (k < 2*JUMP_V+1) cyc();
            if (k == 2*JUMP_V) check("no_early_land", landed_cnt, base);
        end
        e = land_q.pop_front();
        if (init_at_check) begin
            game_init = 1'b1;
            cyc();
            game_init = 1'b0;
            check_reset("init_at_check");
            check("init_at_check_cnt", landed_cnt, base);
            cur_col = START_COL;
        end else begin
            w = 0;
            while (character_landed !== 1'b1 && w < 8) begin
                cyc();
                w++;
            end
            check("land_seen", character_landed, 1);
            cyc();
            check("land_pulse_cnt", landed_cnt, base + 1);
            check("land_col", col, e.col);
            if (e.chk_x) check("land_x", char_x, e.x);
            check("land_y", char_y, Y_STAND);
            check("land_fail", jump_fail, e.fail);
            if (!e.fail) begin
                check("land_busy", busy, 0);
                cur_col = e.col;
            end
        end
    endtask

    task automatic do_fall();
        int y;
        int vy;
        int base;
        bit hit;
        y = Y_STAND;
        vy = 1;
        hit = 1'b0;
        base = landed_cnt;
        check("fall_busy", busy, 1);
        for (int k = 0; k < 40 && !hit; k++) begin
            y += vy;
            if (y >= Y_FLOOR) begin
                y = Y_FLOOR;
                hit = 1'b1;
            end
            if (vy < 15) vy++;
            y_q.push_back(y);
            tick();
            check("fall_y", char_y, y_q.pop_front());
            cyc();
        end
        check("fall_land_cnt", landed_cnt, base + 1);
        check("fall_down_busy", busy, 0);
        check("fall_fail_hold", jump_fail, 1);
        check("fall_y_final", char_y, Y_FLOOR);
        check("no_double_landed", double_cnt, 0);
    endtask

    initial begin
        rst = 1'b0;
        frame_tick = 1'b0;
        game_init = 1'b0;
        jump_left = 1'b0;
        jump_right = 1'b0;
        layer_mask = 8'h00;
        cur_col = START_COL;
        repeat (3) cyc();
        check_reset("reset");
        rst = 1'b1;
        cyc();

        // asynchronous reset after 5 flight ticks
        layer_mask = 8'b0001_0000;
        jump_right = 1'b1;
        cyc();
        jump_right = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            cyc();
        end
        check("mid_busy", busy, 1);
        check("mid_y", char_y, 400 - 8 - 7 - 6 - 5 - 4);
        rst = 1'b0;
        #1;
        check_reset("async_rst");
        cyc();
        rst = 1'b1;
        cyc();

        // successful jump right onto column 4
        layer_mask = 8'b0001_0000;
        do_jump(1'b0, 1'b0, 1'b0);
        check("right_col", col, 4);
        check("right_x", char_x, 288);
        pulse_init();
        check_reset("init1");

        // failed jump left, then fall to the floor
        layer_mask = 8'b0000_0000;
        do_jump(1'b1, 1'b0, 1'b0);
        do_fall();
        pulse_init();
        check_reset("init2");

        // both commands together are ignored
        layer_mask = 8'hFF;
        jump_left = 1'b1;
        jump_right = 1'b1;
        cyc();
        jump_left = 1'b0;
        jump_right = 1'b0;
        cyc();
        check("both_busy", busy, 0);
        tick();
        cyc();
        check("both_y", char_y, Y_STAND);
        check("both_x", char_x, X_OFF + START_COL*COL_W);

        // stray command mid-flight, then walk to the left edge
        do_jump(1'b1, 1'b1, 1'b0);
        do_jump(1'b1, 1'b0, 1'b0);
        do_jump(1'b1, 1'b0, 1'b0);
        check("edge_col0", col, 0);
        layer_mask = 8'b1000_0000;
        do_jump(1'b1, 1'b0, 1'b0);
        pulse_init();
        check_reset("init3");

        // game_init lands on the CHECK cycle
        layer_mask = 8'hFF;
        do_jump(1'b0, 1'b0, 1'b1);
        cyc();
        check("post_init_cnt_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jump_ctl.md
Name: jump_ctl

Overview:
Sequences the character's motion datapath for the game. It accepts one-cycle jump_left/jump_right commands from the game state machine and steps the character's pixel position once per video frame along a parabolic arc. On arrival it checks the target column against the current block layer, then reports character_landed and jump_fail back to the state machine. On failure it runs the fall animation to the floor.

Parameters:
COLS, 8, number of block columns (column index 0..COLS-1)
COL_W, 64, column pitch in pixels
X_OFF, 32, pixel x of column 0 centre
Y_STAND, 400, pixel y of character standing on a block
Y_FLOOR, 700, pixel y at which a fall ends
JUMP_V, 8, initial upward speed in px/frame; flight lasts 2*JUMP_V+1 frames
DX, 4, horizontal px/frame during flight
START_COL, 3, column loaded by game_init

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
game_init  in  1  one-cycle pulse; reload start position and clear fail
jump_left  in  1  one-cycle jump command, toward column-1
jump_right  in  1  one-cycle jump command, toward column+1
layer_mask  in  COLS  bit i = block present in column i of the current layer
char_x  out  11  character pixel x
char_y  out  10  character pixel y
col  out  $clog2(COLS)  current or target column
busy  out  1  high while in flight or falling
character_landed  out  1  one-cycle pulse at end of flight or fall
jump_fail  out  1  level; high from a failed landing until game_init

Behaviour:
- Reset (rst low, asynchronous): state IDLE; col=START_COL; char_x=X_OFF+START_COL*COL_W; char_y=Y_STAND; vy=0; busy=0; character_landed=0; jump_fail=0.
- States: IDLE, ARM, FLY, CHECK, FALL, DOWN.
- IDLE:
  - jump_left XOR jump_right high -> latch the direction, go to ARM.
  - Both high in the same cycle -> ignore both.
  - Commands arriving in any other state are ignored.
  - In IDLE with jump_fail=1, the block goes directly to FALL on the next cycle.
- ARM: vy=-JUMP_V; frame counter=0; busy=1. Wait for the next frame_tick, then go to FLY. The first motion step occurs on that tick.
- FLY, on each frame_tick:
  - char_y += vy, then vy += 1.
  - char_x += DX or -DX according to the latched direction.
  - counter += 1.
  - After the (2*JUMP_V+1)-th tick, char_y equals Y_STAND exactly; go to CHECK.
- CHECK (1 cycle):
  - Compute the target column t = col±1.
  - Snap char_x = X_OFF + t*COL_W.
  - Pulse character_landed.
  - t in range and layer_mask[t]=1 -> col=t, busy=0, go to IDLE.
  - Otherwise -> jump_fail=1 from the next cycle, go to IDLE. col is set to t clamped to 0..COLS-1 for drawing.
  - jump_fail is therefore stable high while the state machine sits in its idle state.
- FALL: busy=1, vy starts at 1. On each frame_tick: char_y += vy, vy += 1 saturating at 15. When char_y >= Y_FLOOR, clamp char_y=Y_FLOOR, pulse character_landed, go to DOWN.
- DOWN: busy=0; hold position and jump_fail; wait for game_init.
- game_init, any state: synchronous return to the reset values, including jump_fail=0. It has priority over every other event in the same cycle.
- Arithmetic: char_y is computed in signed 11 bits internally with no wrap; vy is signed 5 bits.
- character_landed is never high for two consecutive cycles.
- Latency: at least 1 cycle from a command to busy=1; exactly 1 cycle from the last flight tick to character_landed.

Optional Feature:
SKYHOP_EDGE_WRAP_EN
- Defined: target column wraps modulo COLS (col 0 left -> COLS-1, col COLS-1 right -> 0). The snapped char_x uses the wrapped column. Failure occurs only on a missing block.
- Undefined: jumping past either edge always fails as described above.

Decomposition:
- Package skyhop_pkg holds:
  - jump_ctl state encodings
  - COLS, COL_W, Y_STAND, Y_FLOOR defaults
  - K_LEFT/K_RIGHT/K_SPACEBAR key codes shared with the game state machine
- One natural sub-module, jump_trajectory: holds the char_x/char_y/vy registers and applies a step on an enable with a direction. jump_ctl owns the sequencing and the landing check.

Test Plan:
- Reset low mid-flight (after 5 ticks) -> outputs return immediately to col=3, char_x=224, char_y=400, busy=0, jump_fail=0.
- From col=3, layer_mask=8'b0001_0000, jump_right, then 17 ticks -> char_y peaks at 364 after tick 8, is 400 after tick 17; one character_landed pulse; col=4; char_x=288; jump_fail=0.
- From col=3, layer_mask=8'b0000_0000, jump_left, 17 ticks -> character_landed pulse, jump_fail=1. FALL follows; after ticks char_y clamps at 700 with a second single landed pulse. game_init clears to reset values.
- col=0, jump_left -> fail without the macro. With SKYHOP_EDGE_WRAP_EN and layer_mask[7]=1 -> col=7, char_x=480, no fail.
- jump_left and jump_right in the same cycle, and a jump_right during flight -> both ignored; flight path unchanged; exactly 17 ticks to landing.
- game_init coincident with the CHECK cycle -> no landed pulse; reset values next cycle.
